instr_fetch_unit: RTL and testbench

- Instruction-side responder to the control unit's `inc_ip` request.
- Owns the instruction pointer and issues 16-bit word reads to instruction memory.
- Buffers fetched words in a small prefetch queue and presents the head opcode as `instruction[4:0]`.
- While no instruction is available, it presents `INST_DELAY_SLOT` (5'b11001), so the control unit idles safely.
- Jumps, calls, returns and interrupts redirect it through `load_ip`.

---
 rtl/instr_fetch_unit_pkg.sv | 56 +++++
 rtl/instr_fetch_unit_fetch_queue.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode map, instruction
// word layout and fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned OPND_W   = 11;

  // Field positions inside a 16-bit instruction word
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned OPND_MSB = 10;
  localparam int unsigned OPND_LSB = 0;

  // Opcode map
  localparam logic [OPCODE_W-1:0] INST_NOP        = 5'd0;
  localparam logic [OPCODE_W-1:0] INST_LDI        = 5'd1;
  localparam logic [OPCODE_W-1:0] INST_LD         = 5'd2;
  localparam logic [OPCODE_W-1:0] INST_ST         = 5'd3;
  localparam logic [OPCODE_W-1:0] INST_ADD        = 5'd4;
  localparam logic [OPCODE_W-1:0] INST_SUB        = 5'd5;
  localparam logic [OPCODE_W-1:0] INST_AND        = 5'd6;
  localparam logic [OPCODE_W-1:0] INST_OR         = 5'd7;
  localparam logic [OPCODE_W-1:0] INST_XOR        = 5'd8;
  localparam logic [OPCODE_W-1:0] INST_NOT        = 5'd9;
  localparam logic [OPCODE_W-1:0] INST_SHL        = 5'd10;
  localparam logic [OPCODE_W-1:0] INST_SHR        = 5'd11;
  localparam logic [OPCODE_W-1:0] INST_CMP        = 5'd12;
  localparam logic [OPCODE_W-1:0] INST_JMP        = 5'd13;
  localparam logic [OPCODE_W-1:0] INST_JZ         = 5'd14;
  localparam logic [OPCODE_W-1:0] INST_JNZ        = 5'd15;
  localparam logic [OPCODE_W-1:0] INST_CALL       = 5'd16;
  localparam logic [OPCODE_W-1:0] INST_RET        = 5'd17;
  localparam logic [OPCODE_W-1:0] INST_PUSH       = 5'd18;
  localparam logic [OPCODE_W-1:0] INST_POP        = 5'd19;
  localparam logic [OPCODE_W-1:0] INST_IN         = 5'd20;
  localparam logic [OPCODE_W-1:0] INST_OUT        = 5'd21;
  localparam logic [OPCODE_W-1:0] INST_IRET       = 5'd22;
  localparam logic [OPCODE_W-1:0] INST_MUL        = 5'd23;
  localparam logic [OPCODE_W-1:0] INST_DIV        = 5'd24;
  localparam logic [OPCODE_W-1:0] INST_DELAY_SLOT = 5'b11001;

  // Instruction word as presented to the control unit
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [OPND_W-1:0]   operand;
  } instr_word_t;

  // Fetch FSM states
  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of {addr, word}; flush wins over
// push/pop, and push+pop in one cycle keeps the count and advances the head.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the instruction pointer, keeps a small prefetch queue
// filled from instruction memory (one outstanding read at a time) and presents
// the head word to the control unit. load_ip redirects and flushes.
// Optional FETCH_PERF_EN adds stall_cycles / flush_count saturating counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_ip,
  input  logic                load_ip,
  input  logic [ADDR_W-1:0]   new_ip,
  output logic [OPCODE_W-1:0] instruction,
  output logic [OPND_W-1:0]   operand,
  output logic                instruction_valid,
  output logic [ADDR_W-1:0]   ip,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [WORD_W-1:0]   mem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         stall_cycles,
  output logic [15:0]         flush_count
`endif
);

  localparam int unsigned DATA_W = ADDR_W + WORD_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fptr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q;

  logic [DATA_W-1:0] q_head;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  logic [ADDR_W-1:0] q_head_addr;
  instr_word_t       head_c;
  logic              pop_c;
  logic              push_c;
  logic              slot_free_c;

  // Queue control: redirect beats both consume and fill
  always_comb begin
    pop_c       = inc_ip && !q_empty && !load_ip;
    push_c      = (state_q == F_WAIT) && mem_ack && !load_ip;
    slot_free_c = (q_count < CNT_W'(DEPTH)) || pop_c;
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .flush_i     (load_ip),
    .push_data_i ({mem_addr_q, mem_rdata}),
    .head_data_o (q_head),
    .count_o     (q_count),
    .empty_o     (q_empty)
  );

  // Fetch FSM: request issue, ack handling, redirect and in-flight discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= F_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_IP;
      fptr_q     <= RESET_IP;
    end else begin
      case (state_q)
        F_IDLE: begin
          if (load_ip) begin
            // queue is flushed this cycle, so the new target can go out at once
            fptr_q     <= new_ip;
            mem_req_q  <= 1'b1;
            mem_addr_q <= new_ip;
            state_q    <= F_WAIT;
          end else if (slot_free_c) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fptr_q;
            state_q    <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (load_ip) begin
            fptr_q <= new_ip;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= F_IDLE;
            end else begin
              state_q <= F_DISCARD;
            end
          end else if (mem_ack) begin
            fptr_q    <= fptr_q + ADDR_W'(1);
            mem_req_q <= 1'b0;
            state_q   <= F_IDLE;
          end
        end
        F_DISCARD: begin
          if (load_ip) begin
            fptr_q <= new_ip;
          end
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= F_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= F_IDLE;
        end
      endcase
    end
  end

  assign q_head_addr       = q_head[DATA_W-1:WORD_W];
  assign head_c            = instr_word_t'(q_head[WORD_W-1:0]);
  assign instruction       = q_empty ? INST_DELAY_SLOT : head_c.opcode;
  assign operand           = q_empty ? '0 : head_c.operand;
  assign instruction_valid = !q_empty;
  assign ip                = q_empty ? fptr_q : q_head_addr;
  assign mem_req           = mem_req_q;
  assign mem_addr          = mem_addr_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters of empty-queue cycles and redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (q_empty && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (load_ip && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect/latency scenarios plus a
// randomized run against an instruction-stream model (ip sequence, head
// contents, request hold and prefetch depth).
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [4:0]  DELAY_OP = 5'b11001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc_ip;
  logic        load_ip;
  logic [15:0] new_ip;
  logic [4:0]  instruction;
  logic [10:0] operand;
  logic        instruction_valid;
  logic [15:0] ip;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  int unsigned stall_m;
  int unsigned flush_m;
`endif

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DEPTH    (DEPTH),
    .RESET_IP (16'h0000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inc_ip            (inc_ip),
    .load_ip           (load_ip),
    .new_ip            (new_ip),
    .instruction       (instruction),
    .operand           (operand),
    .instruction_valid (instruction_valid),
    .ip                (ip),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  // stream model
  logic [15:0] pc;
  bit          stale;
  int          invalid_run;
  logic        valid_seen;
  logic        prev_req;
  logic        prev_ack;
  logic [15:0] prev_addr;

  // memory model
  int          wait_cnt;
  int          lat;
  bit          rand_lat;
  bit          mem_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    if (mem_zero) return 16'h0000;
    return 16'(a * 16'd40503 + 16'h2803);
  endfunction

  // Memory answers after `lat` wait cycles; mem_rdata is junk when not acking
  task automatic mem_respond();
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (mem_req && (wait_cnt >= lat)) begin
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
    end
  endtask

  task automatic check_cycle();
    logic [15:0] w;
    check("ip", 32'(ip), 32'(pc));
    if (instruction_valid) begin
      w = word_of(pc);
      check("head_opcode", 32'(instruction), 32'(w[15:11]));
      check("head_operand", 32'(operand), 32'(w[10:0]));
      invalid_run = 0;
    end else begin
      check("empty_opcode", 32'(instruction), 32'(DELAY_OP));
      check("empty_operand", 32'(operand), 32'd0);
      invalid_run++;
      check("starve", 32'(invalid_run > 20), 32'd0);
    end
    if (prev_req && !prev_ack) begin
      check("req_hold", 32'(mem_req), 32'd1);
      check("addr_hold", 32'(mem_addr), 32'(prev_addr));
    end
    if (mem_req && !stale) begin
      check("prefetch_depth", 32'(16'(mem_addr - ip) < 16'(DEPTH)), 32'd1);
    end
`ifdef FETCH_PERF_EN
    check("stall_cycles", 32'(stall_cycles), 32'(stall_m));
    check("flush_count", 32'(flush_count), 32'(flush_m));
`endif
  endtask

  // One clock: memory response, edge, model update, check at the falling edge
  task automatic tick();
    mem_respond();
    valid_seen = instruction_valid;
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    prev_ack   = mem_ack;
    @(posedge clk);
    if (mem_ack) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (prev_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    if (load_ip) begin
      pc          = new_ip;
      stale       = prev_req && !prev_ack;
      invalid_run = 0;
    end else begin
      if (inc_ip && valid_seen) pc = pc + 16'd1;
      if (prev_ack) stale = 1'b0;
    end
`ifdef FETCH_PERF_EN
    if (load_ip && flush_m < 65535) flush_m++;
    if (!valid_seen && stall_m < 65535) stall_m++;
`endif
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    inc_ip  = 1'b0;
    load_ip = 1'b0;
    new_ip  = 16'h0000;
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_opcode", 32'(instruction), 32'(DELAY_OP));
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_valid", 32'(instruction_valid), 32'd0);
    check("rst_ip", 32'(ip), 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_flush", 32'(flush_count), 32'd0);
    stall_m = 0;
    flush_m = 0;
`endif
    rst_n       = 1'b1;
    pc          = 16'h0000;
    stale       = 1'b0;
    invalid_run = 0;
    wait_cnt    = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_addr   = 16'h0000;
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int k = 0;
    while (mem_req !== lvl && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(mem_req), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (instruction_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(instruction_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    mem_zero = 1'b0;
    rand_lat = 1'b0;
    lat      = 0;

    // first fetch after reset, zero-wait memory
    do_reset();
    tick();
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h0);
    check("t1_valid_early", 32'(instruction_valid), 32'd0);
    tick();
    check("t1_valid", 32'(instruction_valid), 32'd1);
    check("t1_opcode", 32'(instruction), 32'h05);
    check("t1_operand", 32'(operand), 32'h003);
    check("t1_ip", 32'(ip), 32'h0);

    // continuous consume over all-zero memory
    mem_zero = 1'b1;
    do_reset();
    inc_ip = 1'b1;
    repeat (6) tick();
    inc_ip = 1'b0;
    check("t2_ip", 32'(ip), 32'h2);
    check("t2_valid", 32'(instruction_valid), 32'd1);
    check("t2_opcode", 32'(instruction), 32'h00);
    mem_zero = 1'b0;

    // redirect while a slow read is in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    load_ip = 1'b1;
    new_ip  = 16'h0040;
    tick();
    load_ip = 1'b0;
    wait_req(1'b0, "t3_old_done");
    wait_req(1'b1, "t3_new_req");
    check("t3_addr", 32'(mem_addr), 32'h0040);
    wait_valid("t3_valid");
    check("t3_ip", 32'(ip), 32'h0040);
    w = word_of(16'h0040);
    check("t3_opcode", 32'(instruction), 32'(w[15:11]));

    // redirect coinciding with an ack
    lat = 0;
    do_reset();
    tick();
    load_ip = 1'b1;
    new_ip  = 16'h0010;
    tick();
    load_ip = 1'b0;
    check("t4_valid", 32'(instruction_valid), 32'd0);
    check("t4_ip", 32'(ip), 32'h0010);
    tick();
    check("t4_req", 32'(mem_req), 32'd1);
    check("t4_addr", 32'(mem_addr), 32'h0010);
    tick();
    check("t4_valid_new", 32'(instruction_valid), 32'd1);
    check("t4_ip_new", 32'(ip), 32'h0010);

    // redirect to the top of the address space and wrap
    do_reset();
    load_ip = 1'b1;
    new_ip  = 16'hFFFF;
    tick();
    load_ip = 1'b0;
    check("t5_req", 32'(mem_req), 32'd1);
    check("t5_addr0", 32'(mem_addr), 32'hFFFF);
    check("t5_valid_early", 32'(instruction_valid), 32'd0);
    tick();
    check("t5_valid", 32'(instruction_valid), 32'd1);
    check("t5_ip0", 32'(ip), 32'hFFFF);
    inc_ip = 1'b1;
    tick();
    check("t5_addr1", 32'(mem_addr), 32'h0000);
    tick();
    check("t5_ip1", 32'(ip), 32'h0000);
    check("t5_valid1", 32'(instruction_valid), 32'd1);
    tick();
    inc_ip = 1'b0;
    check("t5_ip2", 32'(ip), 32'h0001);

`ifdef FETCH_PERF_EN
    // three redirects counted
    do_reset();
    repeat (3) begin
      load_ip = 1'b1;
      new_ip  = 16'(($urandom_range(0, 255)));
      tick();
      load_ip = 1'b0;
      repeat (3) tick();
    end
    check("t6_flush", 32'(flush_count), 32'd3);
`endif

    // randomized traffic with random memory latency
    rand_lat = 1'b1;
    lat      = $urandom_range(0, 3);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      inc_ip  = ($urandom_range(0, 3) != 0);
      load_ip = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) new_ip = 16'hFFFD + 16'($urandom_range(0, 3));
      else                           new_ip = 16'($urandom);
      tick();
    end
    inc_ip  = 1'b0;
    load_ip = 1'b0;

    // reset in the middle of traffic
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
